fifo_burst_reader: RTL and testbench

- Read-side companion of the team's synchronous FIFO.
- Pops words through the FIFO's read port (rd_en / dout / empty) and re-times them into a registered valid/ready stream for downstream consumers.
- Groups words into fixed-length packets, tags the final word with m_last and counts completed packets.
- Sits between a FIFO instance and any stream consumer (DMA writer, serializer, packer).

---
 rtl/fifo_burst_reader.sv | 146 ++++++++++++++
 tb/tb_fifo_burst_reader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - pops FIFO words into a two-entry skid buffer and emits fixed-length packets
// with a registered valid/ready stream, a last-word tag and a completed-packet counter.
module fifo_burst_reader #(
  parameter int WIDTH = 24,
  parameter int BURST = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             busy
);

  localparam int IDX_W = $clog2(BURST);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic             last0_q, last0_d, last1_q, last1_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;

  logic push;
  logic pop;
  logic push_last;

  assign push      = (state_q == RUN) & ~fifo_empty & (occ_q != 2'd2);
  assign pop       = (occ_q != 2'd0) & m_ready;
  assign push_last = (idx_q == IDX_LAST);

  assign fifo_rd_en = push;
  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = data0_q;
  assign m_last     = last0_q & m_valid;
  assign pkt_cnt    = pkt_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    idx_d = idx_q;
    if (push) begin
      idx_d = push_last ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Leaving RUN looks at the post-edge index so the cycle after the last word
  // of a packet is already outside RUN and cannot start another packet.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable && idx_d == '0) state_d = DRAIN;
      DRAIN: begin
        if (enable) begin
          state_d = RUN;
        end else if (occ_q == 2'd0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry 0 is always the head; entry 1 only holds data when occupancy is 2.
  always_comb begin
    occ_d   = occ_q;
    data0_d = data0_q;
    data1_d = data1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          data0_d = fifo_dout;
          last0_d = push_last;
        end else begin
          data1_d = fifo_dout;
          last1_d = push_last;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        data0_d = data1_q;
        last0_d = last1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          data0_d = fifo_dout;
          last0_d = push_last;
        end else begin
          data0_d = data1_q;
          last0_d = last1_q;
          data1_d = fifo_dout;
          last1_d = push_last;
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    pkt_d = pkt_q;
    if (pop && last0_q) begin
      pkt_d = pkt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      occ_q   <= 2'd0;
      data0_q <= '0;
      data1_q <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      occ_q   <= occ_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
      pkt_q   <= pkt_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - bench for fifo_burst_reader: queue-based FIFO and packet stream model
module tb_fifo_burst_reader;
  localparam int WIDTH = 24;
  localparam int BURST = 16;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] fifo_dout = '0;
  logic             fifo_empty = 1'b1;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic             m_last;
  logic [CNT_W-1:0] pkt_cnt;
  logic             busy;

  fifo_burst_reader #(.WIDTH(WIDTH), .BURST(BURST), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .pkt_cnt(pkt_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             l;
    int               c;
  } ent_t;

  logic [WIDTH-1:0] fq[$];
  ent_t             exp_q[$];
  bit               pop_pend, force_empty, hold_pend;
  int               cyc, pop_cyc, midx;
  int               reads_n, hs_n, last_n, lat_min, lat_max;
  int               stream_err, stab_err, uf_err;
  logic [WIDTH-1:0] hold_d;
  logic             hold_l;
  int               pass_cnt = 0;
  int               chk_cnt = 0;

  // Reference: every popped FIFO word must come out in order; the last flag
  // marks every BURST-th word read since reset.
  always @(posedge clk) begin
    ent_t e;
    cyc++;
    pop_pend = fifo_rd_en && !fifo_empty;
    pop_cyc  = cyc;
    if (fifo_rd_en && fifo_empty) uf_err++;
    if (rst_n && hold_pend && (!m_valid || m_data !== hold_d || m_last !== hold_l)) stab_err++;
    hold_pend = rst_n && m_valid && !m_ready;
    hold_d    = m_data;
    hold_l    = m_last;
    if (rst_n && m_valid && m_ready) begin
      hs_n++;
      if (exp_q.size() == 0) begin
        stream_err++;
        $display("note: unexpected word %h at cycle %0d", m_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e.d || m_last !== e.l) begin
          stream_err++;
          $display("note: word got %h/%b expected %h/%b", m_data, m_last, e.d, e.l);
        end
        if (cyc - e.c < lat_min) lat_min = cyc - e.c;
        if (cyc - e.c > lat_max) lat_max = cyc - e.c;
        if (e.l) last_n++;
      end
    end
  end

  always @(negedge clk) begin
    if (pop_pend) begin
      exp_q.push_back('{d: fq[0], l: (midx == BURST - 1), c: pop_cyc});
      void'(fq.pop_front());
      midx = (midx + 1) % BURST;
      reads_n++;
      pop_pend = 1'b0;
    end
    #1;
    fifo_empty = (fq.size() == 0) || force_empty;
    fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
  end

  task automatic clear_model();
    exp_q.delete();
    midx = 0; hold_pend = 1'b0;
    reads_n = 0; hs_n = 0; last_n = 0; lat_min = 1000000; lat_max = 0;
    stream_err = 0; stab_err = 0; uf_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); #3;
    rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; force_empty = 1'b0;
    fq.delete();
    clear_model();
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic push_words(input int n, input bit ramp);
    for (int i = 0; i < n; i++) fq.push_back(ramp ? WIDTH'(i) : WIDTH'($urandom));
  endtask

  task automatic test_reset();
    push_words(4, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #3;
      chk_cnt++;
      if ({fifo_rd_en, m_valid, busy, pkt_cnt} !== '0)
        $display("FAIL reset_outputs: rd_en/valid/busy/pkt = %b/%b/%b/%0d required 0/0/0/0",
                 fifo_rd_en, m_valid, busy, pkt_cnt);
      else pass_cnt++;
    end
  endtask

  task automatic test_basic();
    int run, max_run;
    do_reset();
    push_words(32, 1'b1);
    m_ready = 1'b1; enable = 1'b1;
    run = 0; max_run = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #3;
      if (fifo_rd_en) run++; else run = 0;
      if (run > max_run) max_run = run;
      if (reads_n == 32) enable = 1'b0;
      if (reads_n == 32 && !busy) break;
    end
    chk_cnt++; if (max_run !== 32) $display("FAIL basic_rd_run: got %0d required 32", max_run); else pass_cnt++;
    chk_cnt++; if (hs_n !== 32) $display("FAIL basic_words: got %0d required 32", hs_n); else pass_cnt++;
    chk_cnt++; if (stream_err !== 0) $display("FAIL basic_stream: errors %0d required 0", stream_err); else pass_cnt++;
    chk_cnt++; if (lat_min !== 1 || lat_max !== 1) $display("FAIL basic_latency: min %0d max %0d required 1", lat_min, lat_max); else pass_cnt++;
    chk_cnt++; if (last_n !== 2) $display("FAIL basic_lasts: got %0d required 2", last_n); else pass_cnt++;
    chk_cnt++; if (pkt_cnt !== 2'd2) $display("FAIL basic_pkt_cnt: got %0d required 2", pkt_cnt); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL basic_idle: busy %b required 0", busy); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] d3;
    do_reset();
    push_words(32, 1'b0);
    m_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #3;
      if (hs_n == 3 && m_valid) break;
    end
    chk_cnt++; if (hs_n !== 3 || exp_q.size() == 0) $display("FAIL bp_reach_word3: accepted %0d required 3", hs_n); else pass_cnt++;
    d3 = (exp_q.size() != 0) ? exp_q[0].d : '0;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #3;
      chk_cnt++;
      if (!m_valid || m_data !== d3) $display("FAIL bp_hold: valid %b data %h required 1 %h", m_valid, m_data, d3);
      else pass_cnt++;
    end
    chk_cnt++; if (fifo_rd_en !== 1'b0 || reads_n !== hs_n + 2) $display("FAIL bp_rd_stop: rd_en %b buffered %0d required 0 2", fifo_rd_en, reads_n - hs_n); else pass_cnt++;
    for (int i = 0; i < 400; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk); #3;
      if (reads_n == 32) enable = 1'b0;
      if (reads_n == 32 && !busy) break;
    end
    chk_cnt++; if (hs_n !== 32) $display("FAIL bp_words: got %0d required 32", hs_n); else pass_cnt++;
    chk_cnt++; if (stream_err !== 0 || stab_err !== 0) $display("FAIL bp_stream: order %0d stability %0d required 0 0", stream_err, stab_err); else pass_cnt++;
    chk_cnt++; if (pkt_cnt !== 2'd2) $display("FAIL bp_pkt_cnt: got %0d required 2", pkt_cnt); else pass_cnt++;
  endtask

  task automatic test_enable_drop();
    do_reset();
    push_words(40, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 600; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk); #3;
      if (reads_n >= 6) enable = 1'b0;
      if (reads_n >= 6 && !busy) break;
    end
    chk_cnt++; if (reads_n !== 16) $display("FAIL drop_reads: got %0d required 16", reads_n); else pass_cnt++;
    chk_cnt++; if (fq.size() !== 24) $display("FAIL drop_fifo_left: got %0d required 24", fq.size()); else pass_cnt++;
    chk_cnt++; if (hs_n !== 16 || last_n !== 1) $display("FAIL drop_out: words %0d lasts %0d required 16 1", hs_n, last_n); else pass_cnt++;
    chk_cnt++; if (stream_err !== 0 || stab_err !== 0) $display("FAIL drop_stream: order %0d stability %0d required 0 0", stream_err, stab_err); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0 || pkt_cnt !== 2'd1) $display("FAIL drop_end: busy %b pkt %0d required 0 1", busy, pkt_cnt); else pass_cnt++;
  endtask

  task automatic test_empty_stall();
    do_reset();
    push_words(8, 1'b0);
    m_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #3;
      if (reads_n == 8) break;
    end
    repeat (4) @(negedge clk);
    #3;
    chk_cnt++; if (m_valid !== 1'b0 || busy !== 1'b1 || hs_n !== 8) $display("FAIL stall_state: valid %b busy %b words %0d required 0 1 8", m_valid, busy, hs_n); else pass_cnt++;
    push_words(24, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #3;
      if (reads_n == 32) enable = 1'b0;
      if (reads_n == 32 && !busy) break;
    end
    chk_cnt++; if (hs_n !== 32 || last_n !== 2) $display("FAIL stall_out: words %0d lasts %0d required 32 2", hs_n, last_n); else pass_cnt++;
    chk_cnt++; if (stream_err !== 0 || uf_err !== 0) $display("FAIL stall_stream: order %0d underflow %0d required 0 0", stream_err, uf_err); else pass_cnt++;
    chk_cnt++; if (pkt_cnt !== 2'd2) $display("FAIL stall_pkt_cnt: got %0d required 2", pkt_cnt); else pass_cnt++;
  endtask

  task automatic test_random_stream();
    do_reset();
    push_words(48, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      m_ready     = 1'($urandom_range(0, 1));
      force_empty = ($urandom_range(0, 3) == 0) && reads_n < 48;
      @(negedge clk); #3;
      if (reads_n == 48) enable = 1'b0;
      if (reads_n == 48 && !busy) break;
    end
    force_empty = 1'b0;
    chk_cnt++; if (hs_n !== 48 || last_n !== 3) $display("FAIL rand_out: words %0d lasts %0d required 48 3", hs_n, last_n); else pass_cnt++;
    chk_cnt++; if (stream_err !== 0 || stab_err !== 0 || uf_err !== 0) $display("FAIL rand_stream: order %0d stability %0d underflow %0d required 0", stream_err, stab_err, uf_err); else pass_cnt++;
    chk_cnt++; if (pkt_cnt !== CNT_W'(3)) $display("FAIL rand_pkt_cnt: got %0d required 3", pkt_cnt); else pass_cnt++;
  endtask

  task automatic test_pkt_wrap();
    int seq[$];
    logic [CNT_W-1:0] prev;
    do_reset();
    push_words(64, 1'b0);
    m_ready = 1'b1; enable = 1'b1;
    prev = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #3;
      if (pkt_cnt !== prev) begin
        seq.push_back(int'(pkt_cnt));
        prev = pkt_cnt;
      end
      if (reads_n == 64) enable = 1'b0;
      if (reads_n == 64 && !busy) break;
    end
    chk_cnt++; if (seq.size() !== 4) $display("FAIL wrap_steps: got %0d required 4", seq.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (i >= seq.size() || seq[i] !== (i + 1) % 4)
        $display("FAIL wrap_value_%0d: got %0d required %0d", i, (i < seq.size()) ? seq[i] : -1, (i + 1) % 4);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_words(56, 1'b0);
    m_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #3;
      if (hs_n >= 16) break;
    end
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #3;
      if (!fifo_rd_en && reads_n - hs_n == 2) break;
    end
    chk_cnt++; if (pkt_cnt !== 2'd1 || reads_n - hs_n !== 2) $display("FAIL rmid_pre: pkt %0d buffered %0d required 1 2", pkt_cnt, reads_n - hs_n); else pass_cnt++;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk_cnt++; if ({fifo_rd_en, m_valid, busy, pkt_cnt} !== '0) $display("FAIL rmid_async: rd_en/valid/busy/pkt = %b/%b/%b/%0d required 0", fifo_rd_en, m_valid, busy, pkt_cnt); else pass_cnt++;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 600; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk); #3;
      if (reads_n >= 3) enable = 1'b0;
      if (reads_n >= 3 && !busy) break;
    end
    chk_cnt++; if (reads_n !== 16 || hs_n !== 16 || last_n !== 1) $display("FAIL rmid_packet: reads %0d words %0d lasts %0d required 16 16 1", reads_n, hs_n, last_n); else pass_cnt++;
    chk_cnt++; if (stream_err !== 0 || pkt_cnt !== 2'd1) $display("FAIL rmid_stream: order %0d pkt %0d required 0 1", stream_err, pkt_cnt); else pass_cnt++;
  endtask

  initial begin
    cyc = 0; pop_pend = 1'b0; force_empty = 1'b0;
    clear_model();
    test_reset();
    test_basic();
    test_backpressure();
    test_enable_drop();
    test_empty_stall();
    test_random_stream();
    test_pkt_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
